pcf8591_dac_responder: RTL and testbench

I2C target (slave) model of the PCF8591 DAC write path. It is the far end of the DAC transmitter link: it decodes START/STOP, matches the address byte, ACKs the control byte and the streamed DAC data bytes, and presents each received DAC value with a one-cycle strobe. It sits on the board-level SCL/SDA nets and serves as an in-FPGA loopback target for link bring-up and self-test.

---
 rtl/pcf8591_dac_responder_pkg.sv | 26 ++
 rtl/pcf8591_dac_responder_i2c_line_monitor.sv | 51 +++++
 rtl/pcf8591_dac_responder.sv | 133 +++++++++++++
 tb/tb_pcf8591_dac_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcf8591_dac_responder_pkg.sv
// Shared types and PCF8591 constants for the DAC write-path I2C target.
package pcf8591_dac_responder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StCtrl,
    StCtrlAck,
    StData,
    StDataAck,
    StIgnore
  } state_e;

  localparam logic [6:0]  Pcf8591Addr   = 7'h48;
  localparam logic        WriteBit      = 1'b0;
  localparam int unsigned DacEnableBit  = 6;
  localparam logic [7:0]  AnalogOutMask = 8'(1) << DacEnableBit;
  localparam int unsigned SyncDepth     = 2;

  // Only a write to our own address is acknowledged; reads are not served.
  function automatic logic addr_write_match(logic [7:0] addr_byte, logic [6:0] dev_addr);
    return addr_byte == {dev_addr, WriteBit};
  endfunction

endpackage

// File: rtl/pcf8591_dac_responder_i2c_line_monitor.sv
// SCL/SDA synchronisers plus registered SCL edge and START/STOP condition pulses.
module pcf8591_dac_responder_i2c_line_monitor
  import pcf8591_dac_responder_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_bit_o
);

  logic [SyncDepth-1:0] scl_sync_q;
  logic [SyncDepth-1:0] sda_sync_q;
  logic                 scl_prev_q;
  logic                 sda_prev_q;
  logic                 scl_s;
  logic                 sda_s;

  assign scl_s = scl_sync_q[SyncDepth-1];
  assign sda_s = sda_sync_q[SyncDepth-1];

  // Idle bus is high on both lines, so reset the pipeline to 1 to avoid false edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      sda_bit_o  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncDepth-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SyncDepth-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      scl_rise_o <= scl_s & ~scl_prev_q;
      scl_fall_o <= ~scl_s & scl_prev_q;
      start_o    <= scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      stop_o     <= scl_s & scl_prev_q & ~sda_prev_q & sda_s;
      sda_bit_o  <= sda_s;
    end
  end

endmodule

// File: rtl/pcf8591_dac_responder.sv
// PCF8591 DAC write-path I2C target: address match, control byte capture and
// streamed DAC data bytes, each presented with a one-cycle strobe.
module pcf8591_dac_responder
  import pcf8591_dac_responder_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS  = Pcf8591Addr,
  parameter logic [7:0] RESET_DAC_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] dac_value,
  output logic       dac_strobe,
  output logic [7:0] control_byte,
  output logic       dac_enable,
  output logic       busy
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic       sda_bit;

  state_e     state_q;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       sda_drive_q;
  logic [7:0] rx_byte;
  logic       last_bit;

  pcf8591_dac_responder_i2c_line_monitor u_line_monitor (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (SCL),
    .sda_i      (SDA),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_cond),
    .stop_o     (stop_cond),
    .sda_bit_o  (sda_bit)
  );

  assign rx_byte  = {shift_q, sda_bit};
  assign last_bit = (bit_cnt_q == 3'd7);

  // Open drain: only ever pull low or release.
  assign SDA = sda_drive_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sda_drive_q  <= 1'b0;
      dac_value    <= RESET_DAC_VALUE;
      dac_strobe   <= 1'b0;
      control_byte <= '0;
      dac_enable   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dac_strobe <= 1'b0;
      if (stop_cond) begin
        state_q     <= StIdle;
        bit_cnt_q   <= '0;
        sda_drive_q <= 1'b0;
        busy        <= 1'b0;
      end else if (start_cond) begin
        state_q     <= StAddr;
        bit_cnt_q   <= '0;
        sda_drive_q <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StIgnore: begin
            sda_drive_q <= 1'b0;
          end

          StAddr, StCtrl, StData: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit) begin
                case (state_q)
                  StAddr: begin
                    if (addr_write_match(rx_byte, DEVICE_ADDRESS)) begin
                      state_q <= StAddrAck;
                      busy    <= 1'b1;
                    end else begin
                      state_q <= StIgnore;
                    end
                  end
                  StCtrl: begin
                    control_byte <= rx_byte;
                    dac_enable   <= |(rx_byte & AnalogOutMask);
                    state_q      <= StCtrlAck;
                  end
                  default: begin
                    dac_value  <= rx_byte;
                    dac_strobe <= 1'b1;
                    state_q    <= StDataAck;
                  end
                endcase
              end
            end
          end

          // First SCL fall opens the ACK slot, the second closes it.
          StAddrAck, StCtrlAck, StDataAck: begin
            if (scl_fall) begin
              if (!sda_drive_q) begin
                sda_drive_q <= 1'b1;
              end else begin
                sda_drive_q <= 1'b0;
                case (state_q)
                  StAddrAck: state_q <= StCtrl;
                  default:   state_q <= StData;
                endcase
              end
            end
          end

          default: begin
            state_q     <= StIdle;
            sda_drive_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcf8591_dac_responder.sv
// Directed bench for the PCF8591 DAC responder with a strobe scoreboard.
module tb_pcf8591_dac_responder;

  localparam int Q = 20;  // clk cycles per quarter SCL period

  logic       clk;
  logic       reset;
  logic       scl_drv;
  logic       sda_rel;
  wire        sda_bus;
  logic [7:0] dac_value;
  logic       dac_strobe;
  logic [7:0] control_byte;
  logic       dac_enable;
  logic       busy;

  int         vectors;
  int         miscompares;
  logic [7:0] sb_q[$];

  pullup (sda_bus);
  assign sda_bus = sda_rel ? 1'bz : 1'b0;

  pcf8591_dac_responder dut (
    .clk          (clk),
    .reset        (reset),
    .SCL          (scl_drv),
    .SDA          (sda_bus),
    .dac_value    (dac_value),
    .dac_strobe   (dac_strobe),
    .control_byte (control_byte),
    .dac_enable   (dac_enable),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest expected DAC byte.
  always @(negedge clk) begin
    if (reset === 1'b1 && dac_strobe === 1'b1) begin
      check("strobe_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) check("strobe_value", dac_value, sb_q.pop_front());
    end
  end

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_rel = 1'b1; wq();
    scl_drv = 1'b1; wq();
    sda_rel = 1'b0; wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_rel = 1'b0; wq();
    scl_drv = 1'b1; wq();
    sda_rel = 1'b1; wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_rel = b[7-i]; wq();
      scl_drv = 1'b1;   wq(2);
      scl_drv = 1'b0;   wq();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    send_bits(b, 8);
    sda_rel = 1'b1; wq();
    scl_drv = 1'b1; wq();
    check({tag, "_ack"}, 32'(sda_bus === 1'b0), 32'(exp_ack));
    wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic data_byte(input logic [7:0] b);
    sb_q.push_back(b);
    send_byte(b, 1'b1, "data");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda"}, 32'(sda_bus), 32'd1);
    check({tag, "_dac"}, dac_value, 32'h00);
    check({tag, "_ctrl"}, control_byte, 32'h00);
    check({tag, "_en"}, 32'(dac_enable), 32'd0);
    check({tag, "_strobe"}, 32'(dac_strobe), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    scl_drv     = 1'b1;
    sda_rel     = 1'b1;

    // 1: reset held while the bus toggles
    repeat (3) begin
      scl_drv = 1'b0; wq();
      sda_rel = 1'b0; wq();
      scl_drv = 1'b1; wq();
      sda_rel = 1'b1; wq();
    end
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    wq(2);
    check_reset_outputs("rst_rel");

    // 2: single data byte
    i2c_start();
    send_byte(8'h90, 1'b1, "t2_addr");
    send_byte(8'h40, 1'b1, "t2_ctrl");
    check("t2_ctrl_val", control_byte, 32'h40);
    check("t2_en", 32'(dac_enable), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    data_byte(8'hA5);
    i2c_stop();
    wq();
    check("t2_busy_stop", 32'(busy), 32'd0);
    check("t2_dac", dac_value, 32'hA5);
    check("t2_sb_empty", sb_q.size(), 32'd0);

    // 3: streamed data bytes
    i2c_start();
    send_byte(8'h90, 1'b1, "t3_addr");
    send_byte(8'h40, 1'b1, "t3_ctrl");
    data_byte(8'h11);
    data_byte(8'h22);
    data_byte(8'h33);
    i2c_stop();
    wq();
    check("t3_dac", dac_value, 32'h33);
    check("t3_sb_empty", sb_q.size(), 32'd0);

    // 4: wrong address, then read request
    i2c_start();
    send_byte(8'h92, 1'b0, "t4_waddr");
    send_byte(8'h00, 1'b0, "t4_wctrl");
    send_byte(8'h55, 1'b0, "t4_wdata");
    i2c_stop();
    wq();
    check("t4_ctrl", control_byte, 32'h40);
    check("t4_en", 32'(dac_enable), 32'd1);
    check("t4_dac", dac_value, 32'h33);
    i2c_start();
    send_byte(8'h91, 1'b0, "t4_raddr");
    send_byte(8'h00, 1'b0, "t4_rctrl");
    send_byte(8'h55, 1'b0, "t4_rdata");
    i2c_stop();
    wq();
    check("t4r_ctrl", control_byte, 32'h40);
    check("t4r_dac", dac_value, 32'h33);
    check("t4r_busy", 32'(busy), 32'd0);

    // 5: partial byte then STOP; partial byte then repeated START
    i2c_start();
    send_byte(8'h90, 1'b1, "t5_addr");
    send_byte(8'h40, 1'b1, "t5_ctrl");
    send_bits(8'hF0, 4);
    i2c_stop();
    wq();
    check("t5_dac_kept", dac_value, 32'h33);
    check("t5_busy", 32'(busy), 32'd0);
    i2c_start();
    send_byte(8'h90, 1'b1, "t5b_addr");
    send_byte(8'h40, 1'b1, "t5b_ctrl");
    send_bits(8'hF0, 4);
    i2c_start();
    send_byte(8'h90, 1'b1, "t5r_addr");
    send_byte(8'h40, 1'b1, "t5r_ctrl");
    data_byte(8'h7E);
    i2c_stop();
    wq();
    check("t5_dac", dac_value, 32'h7E);
    check("t5_sb_empty", sb_q.size(), 32'd0);

    // 6: reset while the data ACK is being driven
    i2c_start();
    send_byte(8'h90, 1'b1, "t6_addr");
    send_byte(8'h40, 1'b1, "t6_ctrl");
    sb_q.push_back(8'hC3);
    send_bits(8'hC3, 8);
    sda_rel = 1'b1;
    wq();
    check("t6_ack_low", 32'(sda_bus), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    wq();
    reset = 1'b1;
    scl_drv = 1'b1;
    wq(2);
    i2c_start();
    send_byte(8'h90, 1'b1, "t6b_addr");
    send_byte(8'h40, 1'b1, "t6b_ctrl");
    data_byte(8'h3C);
    i2c_stop();
    wq();
    check("t6_dac", dac_value, 32'h3C);
    check("t6_en", 32'(dac_enable), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
